// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for a 6-digit seven-segment display.
// Each digit slot is CLK_DIV cycles: DEAD_CYCLES with every anode off
// (anti-ghosting), then the selected anode is driven low unless the digit
// is blanked or blinked dark. All outputs, including the FSM state exposed
// on scan_state, come straight from flops.
//
// Handshake: there is no valid/ready traffic here. enable is a level:
// sampled high it starts or continues the scan, sampled low it parks the
// scan in IDLE at the next edge without emitting digit_tick/frame_done.
module seven_seg_scan_ctrl #(
  parameter int CLK_DIV      = 50000,
  parameter int DEAD_CYCLES  = 4,
  parameter int BLINK_FRAMES = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [5:0] blank_mask,
  input  logic [5:0] blink_mask,
  output logic [2:0] mux_sel,
  output logic [5:0] an_n,
  output logic       digit_tick,
  output logic       frame_done,
  output logic [1:0] scan_state
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] DEAD_LAST  = CW'(DEAD_CYCLES - 1);
  localparam logic [CW-1:0] SLOT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DEAD = 2'd1,
    ON   = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] slot_cnt, slot_cnt_next;
  logic [FW-1:0] frame_cnt, frame_cnt_next;
  logic          blink_phase, blink_phase_next;
  logic [2:0]    sel_next;
  logic [5:0]    an_next;
  logic          tick_next;
  logic          done_next;

  assign scan_state = state;

  // Register state, counters and every output; reset acts immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      slot_cnt    <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      mux_sel     <= 3'd0;
      an_n        <= 6'b111111;
      digit_tick  <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state       <= state_next;
      slot_cnt    <= slot_cnt_next;
      frame_cnt   <= frame_cnt_next;
      blink_phase <= blink_phase_next;
      mux_sel     <= sel_next;
      an_n        <= an_next;
      digit_tick  <= tick_next;
      frame_done  <= done_next;
    end
  end

  // Next-state, counter, pulse and anode logic; anodes follow the next state
  // so the registered an_n lines up with the state it belongs to.
  always_comb begin
    state_next       = state;
    slot_cnt_next    = slot_cnt;
    frame_cnt_next   = frame_cnt;
    blink_phase_next = blink_phase;
    sel_next         = mux_sel;
    tick_next        = 1'b0;
    done_next        = 1'b0;
    an_next          = 6'b111111;

    if (!enable) begin
      state_next    = IDLE;
      slot_cnt_next = '0;
      sel_next      = 3'd0;
    end else begin
      case (state)
        IDLE: begin
          state_next    = DEAD;
          slot_cnt_next = '0;
          sel_next      = 3'd0;
        end
        DEAD: begin
          slot_cnt_next = slot_cnt + CW'(1);
          if (slot_cnt == DEAD_LAST) state_next = ON;
        end
        ON: begin
          if (slot_cnt == SLOT_LAST) begin
            state_next    = DEAD;
            slot_cnt_next = '0;
            tick_next     = 1'b1;
            if (mux_sel == 3'd5) begin
              sel_next  = 3'd0;
              done_next = 1'b1;
              // Blink phase flips once every BLINK_FRAMES completed frames.
              if (frame_cnt == FRAME_LAST) begin
                frame_cnt_next   = '0;
                blink_phase_next = ~blink_phase;
              end else begin
                frame_cnt_next = frame_cnt + FW'(1);
              end
            end else begin
              sel_next = mux_sel + 3'd1;
            end
          end else begin
            slot_cnt_next = slot_cnt + CW'(1);
          end
        end
        default: begin
          state_next    = IDLE;
          slot_cnt_next = '0;
          sel_next      = 3'd0;
        end
      endcase
    end

    // Light only the selected digit; blanking and blink-dark both win.
    if (state_next == ON) begin
      for (int i = 0; i < 6; i++) begin
        if (sel_next == 3'(i) && !blank_mask[i] &&
            !(blink_mask[i] && blink_phase_next)) begin
          an_next[i] = 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with CLK_DIV=8, DEAD_CYCLES=2,
// BLINK_FRAMES=2. Inputs change just after the falling edge, outputs are
// sampled on the falling edge.
module tb_seven_seg_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic [5:0] blank_mask;
  logic [5:0] blink_mask;
  logic [2:0] mux_sel;
  logic [5:0] an_n;
  logic       digit_tick;
  logic       frame_done;
  logic [1:0] scan_state;

  int checks = 0;
  int errors = 0;
  int ticks  = 0;
  int frames = 0;

  seven_seg_scan_ctrl #(
    .CLK_DIV(8),
    .DEAD_CYCLES(2),
    .BLINK_FRAMES(2)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .blank_mask(blank_mask),
    .blink_mask(blink_mask),
    .mux_sel(mux_sel),
    .an_n(an_n),
    .digit_tick(digit_tick),
    .frame_done(frame_done),
    .scan_state(scan_state)
  );

  // Clock: 10 time-unit period.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected anode pattern with only digit d lit.
  function automatic logic [5:0] lit_pat(input int d);
    logic [5:0] one;
    one = 6'b000001;
    return ~(one << d);
  endfunction

  // Check one full 8-cycle slot of digit d: 2 dark cycles, then 6 cycles
  // lit (or dark if lit=0). Pulses are only expected in the first cycle.
  task automatic check_slot(input int d, input bit lit, input bit tick_first, input bit frame_first);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("sel d%0d k%0d", d, k), 32'(mux_sel), 32'(d));
      check($sformatf("an d%0d k%0d", d, k), 32'(an_n),
            (k < 2 || !lit) ? 32'h3f : 32'(lit_pat(d)));
      check($sformatf("tick d%0d k%0d", d, k), 32'(digit_tick),
            (k == 0) ? 32'(tick_first) : 32'd0);
      check($sformatf("frame d%0d k%0d", d, k), 32'(frame_done),
            (k == 0) ? 32'(frame_first) : 32'd0);
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    enable     = 1'b0;
    blank_mask = 6'd0;
    blink_mask = 6'd0;

    // Reset values.
    repeat (2) @(negedge clk);
    check("rst sel", 32'(mux_sel), 32'd0);
    check("rst an", 32'(an_n), 32'h3f);
    check("rst tick", 32'(digit_tick), 32'd0);
    check("rst frame", 32'(frame_done), 32'd0);
    check("rst state", 32'(scan_state), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle an", 32'(an_n), 32'h3f);
    check("idle state", 32'(scan_state), 32'd0);

    // Test 1: plain scan of one frame.
    enable = 1'b1;
    for (int d = 0; d < 6; d++) check_slot(d, 1'b1, d != 0, 1'b0);

    // Test 2: digit 2 blanked for a frame, timing unchanged.
    blank_mask = 6'b000100;
    for (int d = 0; d < 6; d++) check_slot(d, d != 2, 1'b1, d == 0);
    blank_mask = 6'd0;

    // Test 3: restart from reset, blink digit 0 over 5 frames.
    reset_n = 1'b0;
    @(negedge clk);
    check("rst2 state", 32'(scan_state), 32'd0);
    blink_mask = 6'b000001;
    reset_n = 1'b1;
    for (int f = 1; f <= 5; f++) begin
      for (int d = 0; d < 6; d++) begin
        check_slot(d, (d != 0) || (f <= 2) || (f == 5), !(f == 1 && d == 0),
                   (d == 0) && (f > 1));
      end
    end
    blink_mask = 6'd0;

    // Test 4: drop enable in the lit part of digit 3.
    for (int d = 0; d < 3; d++) check_slot(d, 1'b1, 1'b1, d == 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("d3 sel k%0d", k), 32'(mux_sel), 32'd3);
      check($sformatf("d3 an k%0d", k), 32'(an_n), (k < 2) ? 32'h3f : 32'h37);
    end
    enable = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("dis an", 32'(an_n), 32'h3f);
      check("dis sel", 32'(mux_sel), 32'd0);
      check("dis tick", 32'(digit_tick), 32'd0);
      check("dis frame", 32'(frame_done), 32'd0);
      check("dis state", 32'(scan_state), 32'd0);
    end
    enable = 1'b1;
    check_slot(0, 1'b1, 1'b0, 1'b0);

    // Test 5: asynchronous reset between edges while digit 1 is lit.
    for (int k = 0; k < 3; k++) @(negedge clk);
    check("pre-rst an", 32'(an_n), 32'h3d);
    #2 reset_n = 1'b0;
    #1;
    check("arst sel", 32'(mux_sel), 32'd0);
    check("arst an", 32'(an_n), 32'h3f);
    check("arst tick", 32'(digit_tick), 32'd0);
    check("arst frame", 32'(frame_done), 32'd0);
    check("arst state", 32'(scan_state), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    check_slot(0, 1'b1, 1'b0, 1'b0);

    // Test 6: 1000 frames with random masks and running invariants.
    for (int c = 0; c < 48000; c++) begin
      @(negedge clk);
      check("sel range", 32'(mux_sel <= 3'd5), 32'd1);
      check("an one-hot", 32'($countones(~an_n) <= 1), 32'd1);
      if (digit_tick) ticks++;
      if (frame_done) frames++;
      blank_mask = 6'($urandom_range(0, 63));
      blink_mask = 6'($urandom_range(0, 63));
    end
    check("tick count", 32'(ticks), 32'(6 * frames));
    check("frame count", 32'(frames), 32'd1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
Time-multiplexed scan controller for the 6-digit seven-segment display.
- Drives the 3-bit digit select of the display data mux and the active-low digit anodes.
- Inserts dead time between digits to prevent ghosting.
- Supports per-digit blanking and blinking.
- Sits between the system clock domain and the seven-segment data mux/decoder path.

Parameters:
- CLK_DIV, 50000, clock cycles per digit slot (dead time + on time); must be > DEAD_CYCLES.
- DEAD_CYCLES, 4, cycles per slot with all anodes off after a digit change; must be >= 1.
- BLINK_FRAMES, 32, full 6-digit frames per blink half-period; must be >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  scan enable; low blanks the display and parks the scan.
- blank_mask  in  6  bit i=1 forces digit i dark.
- blink_mask  in  6  bit i=1 makes digit i dark while blink phase = 1.
- mux_sel  out  3  digit select to the data mux, range 0..5.
- an_n  out  6  active-low anode enables; bit i drives digit i.
- digit_tick  out  1  one-cycle pulse when mux_sel advances.
- frame_done  out  1  one-cycle pulse when mux_sel wraps 5->0.

Behaviour:
Reset and output registration:
- One clock, asynchronous active-low reset.
- All outputs are registered.
- Reset values: mux_sel=0, an_n=6'b111111, digit_tick=0, frame_done=0.
- Internal reset values: slot counter=0, frame counter=0, blink_phase=0, state=IDLE.
- Reset mid-scan takes effect immediately, regardless of clk.

State machine:
- IDLE
  - an_n all 1; mux_sel=0; slot counter held at 0.
  - enable=1 sampled -> DEAD at the next edge.
- DEAD
  - an_n all 1; counter increments each cycle.
  - When counter reaches DEAD_CYCLES-1 -> ON.
- ON
  - an_n[mux_sel]=0 unless blank_mask[mux_sel]=1 or (blink_mask[mux_sel]=1 and blink_phase=1).
  - All other an_n bits are 1.
  - When counter reaches CLK_DIV-1 -> DEAD; counter clears.
  - At that same edge mux_sel advances.
  - Slot length is exactly CLK_DIV cycles: DEAD_CYCLES dark, then CLK_DIV-DEAD_CYCLES lit.

Scan sequencing:
- mux_sel sequence is 0,1,2,3,4,5,0,...; values 6 and 7 are never produced.
- digit_tick is high for the one cycle following each mux_sel advance edge.
- frame_done is high in the same cycle as digit_tick when the new mux_sel is 0.

Blink:
- Frame counter increments on each frame_done.
- At BLINK_FRAMES-1 the counter clears and blink_phase toggles.
- blink_phase and the frame counter are frozen while in IDLE.

Masks:
- blank_mask and blink_mask are sampled combinationally each ON cycle into the registered an_n.
- Result: one-cycle latency from a mask change to an_n.
- blank_mask takes priority over blink; the result is the same (dark).

Enable deassert:
- enable=0 in any state -> IDLE at the next edge: an_n all 1, mux_sel=0, slot counter=0.
- No digit_tick or frame_done is generated on this transition.
- Re-enable restarts at digit 0 with a full DEAD period.

Invariants:
- At most one an_n bit is 0 in any cycle.
- an_n is all 1 for DEAD_CYCLES cycles around every mux_sel change.

Test Plan:
Unless stated otherwise: CLK_DIV=8, DEAD_CYCLES=2, BLINK_FRAMES=2.
1. Reset then enable=1, masks=0.
   -> an_n=111111 for 2 cycles, then 111110 for 6 cycles.
   -> mux_sel then 1, digit_tick pulses once.
   -> Pattern repeats for digits 1..5.
   -> frame_done pulses after 48 cycles with mux_sel=0.
2. blank_mask=6'b000100 over a full frame.
   -> an_n never has bit 2 low.
   -> Slot 2 timing is unchanged (8 cycles, digit_tick still pulses).
3. blink_mask=6'b000001 over 4 frames.
   -> Digit 0 lit in frames 1-2, dark in frames 3-4.
   -> blink_phase toggles after every 2nd frame_done.
4. enable dropped mid-ON of digit 3.
   -> Next cycle: an_n=111111, mux_sel=0, no pulse.
   -> Re-enable: 2 dark cycles, then an_n=111110.
5. reset_n asserted asynchronously mid-slot, between clock edges.
   -> Outputs go to reset values immediately.
   -> After release with enable=1, the scan restarts from digit 0.
6. Continuous run of 1000 frames with random masks.
   -> Assert mux_sel <= 5 every cycle.
   -> Assert at most one an_n bit is low every cycle.
   -> Assert digit_tick count = 6 × frame_done count.
